xrv_bus_arb: RTL and testbench

XRV_BUS_ARB -- requirements
Module: xrv_bus_arb

---
 rtl/xrv_bus_arb_pkg.sv | 38 +++
 rtl/xrv_bus_arb.sv | 121 ++++++++++++
 tb/tb_xrv_bus_arb.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xrv_bus_arb_pkg.sv
// ============================================================================
// Module : xrv_bus_arb_pkg
// Brief  : Shared state/owner encodings and arbitration helper for xrv_bus_arb.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package xrv_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam int unsigned CNT_W    = 16;
    localparam logic [3:0]  FETCH_BE = 4'hf;

    // On a tie the port that was not served last gets the bus.
    function automatic owner_e pick_owner(input logic fetch_req,
                                          input logic data_req,
                                          input owner_e last);
        if (fetch_req && data_req)
            return (last == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        else if (data_req)
            return OWN_DATA;
        else
            return OWN_FETCH;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xrv_bus_arb.sv
// ============================================================================
// Module : xrv_bus_arb
// Brief  : Round-robin arbiter sharing one memory port between fetch and data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xrv_bus_arb
    import xrv_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_addr,
    input  logic        i_rd_req,
    output logic        i_rd_ready,
    output logic [31:0] i_rd_data,

    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wr_data,
    input  logic        d_wr_req,
    input  logic        d_rd_req,
    output logic        d_wr_ready,
    output logic        d_rd_ready,
    output logic [31:0] d_rd_data,

    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic        m_we,
    output logic [31:0] m_wdata,
    output logic        m_req,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,

    output logic        err,
    output logic        err_owner
);

    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    arb_state_e       state;
    owner_e           last_owner;
    logic [CNT_W-1:0] tmo_cnt;

    logic   busy;
    logic   tmo_hit;
    logic   done;
    logic   fetch_req;
    logic   data_req;
    owner_e cur_owner;
    owner_e winner;

    assign busy      = (state != IDLE);
    assign fetch_req = i_rd_req;
    assign data_req  = d_wr_req | d_rd_req;
    assign winner    = pick_owner(fetch_req, data_req, last_owner);
    assign cur_owner = (state == BUSY_D) ? OWN_DATA : OWN_FETCH;

    // A late m_ready on the limit cycle still wins over the abort.
    assign tmo_hit = busy && !m_ready && (tmo_cnt == TMO_LIMIT);
    assign done    = busy && (m_ready || tmo_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= OWN_FETCH;
            tmo_cnt    <= '0;
            m_addr     <= '0;
            m_be       <= '0;
            m_we       <= 1'b0;
            m_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req || data_req) begin
                        tmo_cnt <= '0;
                        if (winner == OWN_DATA) begin
                            state   <= BUSY_D;
                            m_addr  <= d_addr;
                            m_be    <= d_be;
                            m_we    <= d_wr_req;
                            m_wdata <= d_wr_data;
                        end else begin
                            state   <= BUSY_I;
                            m_addr  <= i_addr;
                            m_be    <= FETCH_BE;
                            m_we    <= 1'b0;
                            m_wdata <= '0;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (done) begin
                        state      <= IDLE;
                        last_owner <= cur_owner;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_req      = busy && !tmo_hit;

    assign i_rd_ready = (state == BUSY_I) && done;
    assign d_wr_ready = (state == BUSY_D) && m_we && done;
    assign d_rd_ready = (state == BUSY_D) && !m_we && done;
    assign i_rd_data  = m_rdata;
    assign d_rd_data  = m_rdata;

    assign err        = tmo_hit;
    assign err_owner  = cur_owner;

endmodule

`default_nettype wire

// File: tb/tb_xrv_bus_arb.sv
// ============================================================================
// Module : tb_xrv_bus_arb
// Brief  : Directed scoreboard bench for xrv_bus_arb (TIMEOUT=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_xrv_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_rd_req;
    logic        i_rd_ready;
    logic [31:0] i_rd_data;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wr_data;
    logic        d_wr_req;
    logic        d_rd_req;
    logic        d_wr_ready;
    logic        d_rd_ready;
    logic [31:0] d_rd_data;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic        m_we;
    logic [31:0] m_wdata;
    logic        m_req;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        err;
    logic        err_owner;

    xrv_bus_arb #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_rd_req   (i_rd_req),
        .i_rd_ready (i_rd_ready),
        .i_rd_data  (i_rd_data),
        .d_addr     (d_addr),
        .d_be       (d_be),
        .d_wr_data  (d_wr_data),
        .d_wr_req   (d_wr_req),
        .d_rd_req   (d_rd_req),
        .d_wr_ready (d_wr_ready),
        .d_rd_ready (d_rd_ready),
        .d_rd_data  (d_rd_data),
        .m_addr     (m_addr),
        .m_be       (m_be),
        .m_we       (m_we),
        .m_wdata    (m_wdata),
        .m_req      (m_req),
        .m_ready    (m_ready),
        .m_rdata    (m_rdata),
        .err        (err),
        .err_owner  (err_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic owner, input logic [31:0] addr, input logic [3:0] be,
                        input logic we, input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.owner = owner; e.addr = addr; e.be = be; e.we = we; e.wdata = wdata; e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge of the first BUSY cycle.
    task automatic wait_grant();
        int n = 0;
        while (m_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", m_req, 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty_at_grant", 0, 1);
        end else begin
            chk("m_addr", m_addr, sb[0].addr);
            chk("m_be", m_be, sb[0].be);
            chk("m_we", m_we, sb[0].we);
            chk("m_wdata", m_wdata, sb[0].wdata);
        end
    endtask

    // Memory answers in BUSY cycle 'lat' (1 = first BUSY cycle).
    task automatic complete(input int lat);
        exp_t e;
        for (int k = 1; k < lat; k++) begin
            chk("no_early_ready", {i_rd_ready, d_wr_ready, d_rd_ready}, 0);
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            chk("sb_nonempty_at_ready", 0, 1);
            return;
        end
        e = sb.pop_front();
        m_rdata = e.rdata;
        m_ready = 1'b1;
        #1;
        chk("i_rd_ready", i_rd_ready, (e.owner == 1'b0));
        chk("d_wr_ready", d_wr_ready, (e.owner == 1'b1) && e.we);
        chk("d_rd_ready", d_rd_ready, (e.owner == 1'b1) && !e.we);
        chk("rd_data", e.owner ? d_rd_data : i_rd_data, e.rdata);
        chk("no_err_on_done", err, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        if (e.owner) begin
            d_wr_req = 1'b0;
            d_rd_req = 1'b0;
        end else begin
            i_rd_req = 1'b0;
        end
        chk("idle_after_done", m_req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_addr = '0; i_rd_req = 1'b0;
        d_addr = '0; d_be = '0; d_wr_data = '0; d_wr_req = 1'b0; d_rd_req = 1'b0;
        m_ready = 1'b0; m_rdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_m_req", m_req, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_be", m_be, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", {i_rd_ready, d_wr_ready, d_rd_ready}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch, memory answers in the second BUSY cycle
        i_addr = 32'h100; i_rd_req = 1'b1;
        push(0, 32'h100, 4'hf, 0, 32'h0, 32'hDEADBEEF);
        wait_grant();
        complete(2);

        // Tie with last=fetch: data first, then fetch
        @(negedge clk);
        i_addr = 32'h300; i_rd_req = 1'b1;
        d_addr = 32'h200; d_be = 4'h3; d_wr_data = 32'h12345678; d_wr_req = 1'b1;
        push(1, 32'h200, 4'h3, 1, 32'h12345678, 32'hA5A5A5A5);
        push(0, 32'h300, 4'hf, 0, 32'h0, 32'h11110000);
        wait_grant();
        complete(1);
        wait_grant();
        complete(2);

        // Write beats read on the data port
        @(negedge clk);
        d_addr = 32'h204; d_be = 4'h4; d_wr_data = 32'hCAFEF00D;
        d_wr_req = 1'b1; d_rd_req = 1'b1;
        push(1, 32'h204, 4'h4, 1, 32'hCAFEF00D, 32'h0);
        wait_grant();
        complete(1);

        // Data read; inputs change mid-transaction, m_* must hold
        @(negedge clk);
        d_addr = 32'h408; d_be = 4'hc; d_wr_data = 32'h0BAD0BAD; d_rd_req = 1'b1;
        push(1, 32'h408, 4'hc, 0, 32'h0BAD0BAD, 32'h55AA33CC);
        wait_grant();
        d_addr = 32'hFFFF0000; d_be = 4'h0; d_wr_data = 32'h0;
        @(negedge clk);
        chk("hold_m_addr", m_addr, 32'h408);
        chk("hold_m_be", m_be, 4'hc);
        chk("hold_m_wdata", m_wdata, 32'h0BAD0BAD);
        complete(2);

        // Requester withdraws mid-BUSY; completion still delivered
        @(negedge clk);
        i_addr = 32'h500; i_rd_req = 1'b1;
        push(0, 32'h500, 4'hf, 0, 32'h0, 32'h50505050);
        wait_grant();
        i_rd_req = 1'b0;
        complete(3);

        // m_ready on the very cycle the counter hits TIMEOUT: normal completion
        @(negedge clk);
        i_addr = 32'h600; i_rd_req = 1'b1;
        push(0, 32'h600, 4'hf, 0, 32'h0, 32'h60606060);
        wait_grant();
        complete(5);

        // Timeout abort on a data write
        @(negedge clk);
        d_addr = 32'h700; d_be = 4'h1; d_wr_data = 32'h77777777; d_wr_req = 1'b1;
        push(1, 32'h700, 4'h1, 1, 32'h77777777, 32'h0);
        wait_grant();
        repeat (3) @(negedge clk);
        chk("tmo_not_yet_err", err, 0);
        chk("tmo_not_yet_req", m_req, 1);
        @(negedge clk);
        chk("tmo_err", err, 1);
        chk("tmo_err_owner", err_owner, 1);
        chk("tmo_owner_ready", d_wr_ready, 1);
        chk("tmo_other_ready", {i_rd_ready, d_rd_ready}, 0);
        chk("tmo_m_req", m_req, 0);
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        d_wr_req = 1'b0;
        chk("tmo_idle", m_req, 0);
        chk("tmo_err_clear", err, 0);

        // Async reset in BUSY_D with a fetch waiting
        @(negedge clk);
        d_addr = 32'h800; d_be = 4'hf; d_wr_data = 32'h88888888; d_wr_req = 1'b1;
        push(1, 32'h800, 4'hf, 1, 32'h88888888, 32'h0);
        wait_grant();
        i_addr = 32'h900; i_rd_req = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_m_req", m_req, 0);
        chk("arst_ready", {i_rd_ready, d_wr_ready, d_rd_ready}, 0);
        chk("arst_m_addr", m_addr, 0);
        chk("arst_m_we", m_we, 0);
        void'(sb.pop_front());
        d_wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push(0, 32'h900, 4'hf, 0, 32'h0, 32'h99999999);
        @(negedge clk);
        chk("post_rst_first_grant", m_req, 1);
        wait_grant();
        complete(1);

        // m_ready while IDLE is ignored
        @(negedge clk);
        m_rdata = 32'hBADBAD00; m_ready = 1'b1;
        #1;
        chk("idle_mready_ready", {i_rd_ready, d_wr_ready, d_rd_ready}, 0);
        @(negedge clk);
        chk("idle_mready_req", m_req, 0);
        chk("idle_mready_ready2", {i_rd_ready, d_wr_ready, d_rd_ready}, 0);
        chk("idle_mready_err", err, 0);
        m_ready = 1'b0;
        @(negedge clk);
        i_addr = 32'hA00; i_rd_req = 1'b1;
        push(0, 32'hA00, 4'hf, 0, 32'h0, 32'hA0A0A0A0);
        wait_grant();
        complete(1);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
